// File: rtl/grupaa_pkg.sv
// Shared widths, FSM state encoding and burst descriptor for the grupaa scheduler.
package grupaa_pkg;

    localparam int unsigned DEC_W = 3;
    localparam int unsigned LEN_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_e;

    // owner: 0 = requester A, 1 = requester B
    typedef struct packed {
        logic [DEC_W-1:0] dec;
        logic [LEN_W-1:0] len;
        logic             owner;
    } burst_t;

endpackage

// File: rtl/grupaa_sched_if.sv
// Requester/datapath-facing signal bundle of the grupaa burst scheduler.
interface grupaa_sched_if;
    import grupaa_pkg::*;

    logic             iREQ_A;
    logic             iREQ_B;
    logic [DEC_W-1:0] iDEC_A;
    logic [DEC_W-1:0] iDEC_B;
    logic [LEN_W-1:0] iLEN_A;
    logic [LEN_W-1:0] iLEN_B;
    logic             iABORT;
    logic             oGNT_A;
    logic             oGNT_B;
    logic             oDONE_A;
    logic             oDONE_B;
    logic             oEN;
    logic [DEC_W-1:0] oDEC;
    logic             oBUSY;

    modport master (
        output iREQ_A, iREQ_B, iDEC_A, iDEC_B, iLEN_A, iLEN_B, iABORT,
        input  oGNT_A, oGNT_B, oDONE_A, oDONE_B, oEN, oDEC, oBUSY
    );

    modport slave (
        input  iREQ_A, iREQ_B, iDEC_A, iDEC_B, iLEN_A, iLEN_B, iABORT,
        output oGNT_A, oGNT_B, oDONE_A, oDONE_B, oEN, oDEC, oBUSY
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; ptr_i=0 favours req_i[0], ptr_i=1 favours req_i[1].
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/grupaa_sched.sv
// Round-robin burst scheduler driving grupaa iEN/iDEC for LEN cycles per granted request.
module grupaa_sched
    import grupaa_pkg::*;
(
    input  logic           iCLK,
    input  logic           iRST_N,
    grupaa_sched_if.slave  bus
);

    state_e           state_q;
    logic             ptr_q;
    burst_t           burst_q;
    logic             gnt_a_q;
    logic             gnt_b_q;
    logic             done_a_q;
    logic             done_b_q;
    logic             en_q;
    logic [DEC_W-1:0] dec_q;
    logic             busy_q;

    logic [1:0]       req_c;
    logic [1:0]       win_c;
    burst_t           win_burst_c;

    assign req_c = {bus.iREQ_B, bus.iREQ_A};

    rr_arb2 u_arb (
        .req_i (req_c),
        .ptr_i (ptr_q),
        .gnt_o (win_c)
    );

    // Winner descriptor; len holds the remaining count (LEN-1), so LEN=0 wraps to the full 2**LEN_W.
    always_comb begin
        win_burst_c = '0;
        if (win_c[1]) begin
            win_burst_c.dec   = bus.iDEC_B;
            win_burst_c.len   = bus.iLEN_B - LEN_W'(1);
            win_burst_c.owner = 1'b1;
        end else begin
            win_burst_c.dec   = bus.iDEC_A;
            win_burst_c.len   = bus.iLEN_A - LEN_W'(1);
            win_burst_c.owner = 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            burst_q  <= '0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            en_q     <= 1'b0;
            dec_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    en_q  <= 1'b0;
                    dec_q <= '0;
                    if (|win_c) begin
                        state_q <= RUN;
                        burst_q <= win_burst_c;
                        gnt_a_q <= win_c[0];
                        gnt_b_q <= win_c[1];
                        en_q    <= 1'b1;
                        dec_q   <= win_burst_c.dec;
                        busy_q  <= 1'b1;
                        // Next contention favours whoever did not just win.
                        ptr_q   <= win_c[0];
                    end
                end
                RUN: begin
                    if ((burst_q.len == '0) || bus.iABORT) begin
                        state_q  <= GAP;
                        en_q     <= 1'b0;
                        dec_q    <= '0;
                        done_a_q <= ~burst_q.owner;
                        done_b_q <= burst_q.owner;
                    end else begin
                        burst_q.len <= burst_q.len - LEN_W'(1);
                        en_q        <= 1'b1;
                        dec_q       <= burst_q.dec;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                    en_q    <= 1'b0;
                    dec_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    en_q    <= 1'b0;
                    dec_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oGNT_A  = gnt_a_q;
    assign bus.oGNT_B  = gnt_b_q;
    assign bus.oDONE_A = done_a_q;
    assign bus.oDONE_B = done_b_q;
    assign bus.oEN     = en_q;
    assign bus.oDEC    = dec_q;
    assign bus.oBUSY   = busy_q;

endmodule

// File: tb/tb_grupaa_sched.sv
// Directed bench for grupaa_sched: per-cycle expected output vectors queued with stimulus, checked after each edge.
module tb_grupaa_sched;

    logic clk = 1'b0;
    logic rst_n;

    grupaa_sched_if bus ();

    grupaa_sched dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Vector layout: {gnt_a, gnt_b, done_a, done_b, en, dec[2:0], busy}
    logic [8:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;
    string      tag    = "reset";

    function automatic logic [8:0] observe();
        return {bus.oGNT_A, bus.oGNT_B, bus.oDONE_A, bus.oDONE_B,
                bus.oEN, bus.oDEC, bus.oBUSY};
    endfunction

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(9'b0);
    endtask

    // Grant+first enable cycle, n-1 further enable cycles, then the done cycle.
    task automatic push_burst(input logic own, input logic [2:0] d, input int n);
        exp_q.push_back({~own, own, 2'b00, 1'b1, d, 1'b1});
        for (int i = 1; i < n; i++) exp_q.push_back({4'b0000, 1'b1, d, 1'b1});
        exp_q.push_back({2'b00, ~own, own, 1'b0, 3'b000, 1'b1});
    endtask

    task automatic run(input int n);
        logic [8:0] obs;
        logic [8:0] exp;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            obs = observe();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL %s: queue empty, observed %b", tag, obs);
            end else begin
                exp = exp_q.pop_front();
                assert (obs === exp) else begin
                    errors++;
                    $error("FAIL %s: observed %b expected %b", tag, obs, exp);
                end
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.iREQ_A = 1'b0;
        bus.iREQ_B = 1'b0;
        bus.iDEC_A = '0;
        bus.iDEC_B = '0;
        bus.iLEN_A = '0;
        bus.iLEN_B = '0;
        bus.iABORT = 1'b0;

        // Reset state, then idle with a stray abort
        push_idle(2);
        run(2);
        rst_n = 1'b1;
        tag = "idle_abort";
        bus.iABORT = 1'b1;
        push_idle(2);
        run(2);
        bus.iABORT = 1'b0;

        // Single burst A, DEC=010, LEN=5
        tag = "single_a";
        bus.iREQ_A = 1'b1; bus.iDEC_A = 3'b010; bus.iLEN_A = 4'd5;
        push_burst(1'b0, 3'b010, 5);
        push_idle(1);
        run(1);
        bus.iREQ_A = 1'b0;
        run(6);

        // LEN=0 on B means 16 enable cycles
        tag = "len0_b";
        bus.iREQ_B = 1'b1; bus.iDEC_B = 3'b101; bus.iLEN_B = 4'd0;
        push_burst(1'b1, 3'b101, 16);
        push_idle(1);
        run(1);
        bus.iREQ_B = 1'b0;
        run(17);

        // Contention, both held: A, B, A, B with two low-enable cycles between
        tag = "contention";
        bus.iREQ_A = 1'b1; bus.iDEC_A = 3'b111; bus.iLEN_A = 4'd2;
        bus.iREQ_B = 1'b1; bus.iDEC_B = 3'b001; bus.iLEN_B = 4'd3;
        push_burst(1'b0, 3'b111, 2); push_idle(1);
        push_burst(1'b1, 3'b001, 3); push_idle(1);
        push_burst(1'b0, 3'b111, 2); push_idle(1);
        push_burst(1'b1, 3'b001, 3); push_idle(1);
        run(14);
        bus.iREQ_A = 1'b0; bus.iREQ_B = 1'b0;
        run(4);

        // Abort sampled at the end of the 3rd enable cycle of a LEN=10 burst
        tag = "abort";
        bus.iREQ_A = 1'b1; bus.iDEC_A = 3'b011; bus.iLEN_A = 4'd10;
        push_burst(1'b0, 3'b011, 3);
        push_idle(1);
        run(1);
        bus.iREQ_A = 1'b0;
        run(2);
        bus.iABORT = 1'b1;
        run(1);
        bus.iABORT = 1'b0;
        run(1);

        // Pointer now favours B
        tag = "ptr_after_abort";
        bus.iREQ_A = 1'b1; bus.iDEC_A = 3'b100; bus.iLEN_A = 4'd1;
        bus.iREQ_B = 1'b1; bus.iDEC_B = 3'b110; bus.iLEN_B = 4'd1;
        push_burst(1'b1, 3'b110, 1); push_idle(1);
        run(1);
        bus.iREQ_B = 1'b0;
        run(2);
        push_burst(1'b0, 3'b100, 1); push_idle(1);
        run(1);
        bus.iREQ_A = 1'b0;
        run(2);

        // Reset during 2nd RUN cycle of a LEN=8 burst: no done, pointer back to A
        tag = "reset_mid";
        bus.iREQ_A = 1'b1; bus.iDEC_A = 3'b010; bus.iLEN_A = 4'd8;
        exp_q.push_back({2'b10, 2'b00, 1'b1, 3'b010, 1'b1});
        run(1);
        bus.iREQ_A = 1'b0;
        exp_q.push_back({4'b0000, 1'b1, 3'b010, 1'b1});
        run(1);
        rst_n = 1'b0;
        push_idle(1);
        run(1);
        rst_n = 1'b1;
        push_idle(3);
        run(3);

        tag = "post_reset_contention";
        bus.iREQ_A = 1'b1; bus.iDEC_A = 3'b111; bus.iLEN_A = 4'd2;
        bus.iREQ_B = 1'b1; bus.iDEC_B = 3'b001; bus.iLEN_B = 4'd1;
        push_burst(1'b0, 3'b111, 2); push_idle(1);
        run(1);
        bus.iREQ_A = 1'b0;
        run(3);
        push_burst(1'b1, 3'b001, 1); push_idle(1);
        run(1);
        bus.iREQ_B = 1'b0;
        run(2);

        // B withdraws during A's burst; A's code/length change mid-burst is ignored
        tag = "withdraw_change";
        bus.iREQ_A = 1'b1; bus.iDEC_A = 3'b001; bus.iLEN_A = 4'd4;
        bus.iREQ_B = 1'b1; bus.iDEC_B = 3'b011; bus.iLEN_B = 4'd2;
        push_burst(1'b0, 3'b001, 4); push_idle(3);
        run(1);
        bus.iREQ_A = 1'b0; bus.iDEC_A = 3'b110; bus.iLEN_A = 4'd1;
        run(1);
        bus.iREQ_B = 1'b0;
        run(6);

        tag = "drain";
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s: %0d expected vectors left, required 0", tag, exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
